load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH, 32, datapath width; ADDRESS_WIDTH, 5, register-index width.
REQ-002 clk  in  1  rising-edge clock; the only clock.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 start  in  1  memory instruction valid from execute; sampled only in IDLE.
REQ-005 is_store  in  1  1 = store, 0 = load.
REQ-006 funct3  in  3  size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-007 addr  in  DATA_WIDTH  byte address (ALU result).
REQ-008 store_data  in  DATA_WIDTH  store operand (register-file read port 2).
REQ-009 rd  in  ADDRESS_WIDTH  load destination register.
REQ-010 mem_req  out  1  data-memory request, held until accepted.
REQ-011 mem_we  out  1  request is a write.
REQ-012 mem_addr  out  DATA_WIDTH  word-aligned address, addr with bits [1:0] = 00.
REQ-013 mem_wdata  out  DATA_WIDTH  lane-replicated write data.
REQ-014 mem_wstrb  out  4  byte-lane write strobes.
REQ-015 mem_ready  in  1  memory accepts request and, for reads, mem_rdata is valid in the same cycle.
REQ-016 mem_rdata  in  DATA_WIDTH  read word.
REQ-017 busy  out  1  high whenever state is not IDLE; pipeline stall.
REQ-018 done  out  1  one-cycle completion pulse.
REQ-019 fault  out  1  one-cycle pulse with done for a misaligned access or an illegal funct3.
REQ-020 wb_we  out  1  register-file write enable.
REQ-021 wb_rd  out  ADDRESS_WIDTH  register-file write index.
REQ-022 wb_data  out  DATA_WIDTH  register-file write data.

Function
REQ-023 The FSM SHALL have states IDLE, REQ, DONE and ERR.
- IDLE -> REQ: on start with a legal access.
- IDLE -> ERR: on start with an illegal access.
- REQ -> DONE: on mem_ready.
- DONE -> IDLE and ERR -> IDLE: unconditionally.
REQ-024 On start in IDLE, the unit SHALL register is_store, funct3, addr, store_data and rd; input changes after capture SHALL have no effect.
REQ-025 start SHALL be ignored outside IDLE.
REQ-026 An access SHALL be illegal if any of the following holds:
- H/HU with addr[0] = 1;
- W with addr[1:0] != 00;
- load funct3 in {011, 110, 111};
- store funct3 not in {000, 001, 010}.
REQ-027 mem_req SHALL be 1 exactly while in REQ; mem_we, mem_addr, mem_wdata and mem_wstrb SHALL be stable throughout REQ.
REQ-028 Store strobes and data SHALL be:
- SB: wstrb = 1 << addr[1:0], wdata = byte replicated into all four lanes.
- SH: wstrb = 0011 (addr[1] = 0) or 1100 (addr[1] = 1), wdata = halfword replicated into both halves.
- SW: wstrb = 1111, wdata = store_data.
REQ-029 Loads SHALL drive mem_we = 0 and mem_wstrb = 0000.
REQ-030 Load data SHALL be the lane selected by addr[1:0]. B and H SHALL be sign-extended; BU and HU SHALL be zero-extended.
REQ-031 The load result SHALL be registered when mem_ready is seen in REQ and presented in DONE.
REQ-032 In DONE: done = 1, and wb_we = 1 only for a load with rd != 0.
REQ-033 In ERR: done = 1, fault = 1, wb_we = 0, and no memory request is issued.
REQ-034 Latency SHALL be as follows, with start at cycle 0:
- mem_req asserted from cycle 1;
- mem_ready first seen at cycle k >= 1 gives done at cycle k+1;
- a fault gives done at cycle 1.
REQ-035 mem_ready SHALL be ignored outside REQ.
REQ-036 A new start SHALL be accepted in the first IDLE cycle after DONE or ERR (back-to-back throughput of one access per 3 cycles minimum).
REQ-037 wb_rd and wb_data SHALL hold their last values outside DONE; consumers use them only with wb_we.

Reset
REQ-038 When rst = 1 at a clock edge, the state SHALL become IDLE and all outputs SHALL read 0 in the following cycle.
REQ-039 A reset during REQ SHALL drop mem_req at the next edge and discard the access, with no done or wb_we.
REQ-040 rst SHALL take priority over start and mem_ready in the same cycle.

Verification
REQ-041 LW: addr = 0x100, mem_rdata = 0xDEADBEEF, mem_ready at cycle 1 -> cycle 2: done = 1, wb_we = 1, wb_data = 0xDEADBEEF, mem_addr = 0x100.
REQ-042 LB vs LBU: addr = 0x103, mem_rdata = 0x80FF0011 -> LB wb_data = 0xFFFFFF80; LBU wb_data = 0x00000080.
REQ-043 SH: addr = 0x206, store_data = 0x1234ABCD -> mem_we = 1, mem_addr = 0x204, wstrb = 1100, wdata = 0xABCDABCD, done with wb_we = 0.
REQ-044 LW at addr = 0x102 -> cycle 1: done = 1, fault = 1, mem_req never asserted.
REQ-045 mem_ready withheld 5 cycles with start re-pulsed mid-wait -> exactly one request and one done, at cycle 6.
REQ-046 LW with rd = 0 -> done = 1, wb_we = 0. rst in the REQ cycle -> mem_req = 0 next cycle, no done.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store unit: turns one memory instruction from execute into a single
// data-memory transaction and delivers sign/zero-extended load results to writeback.
module load_store_unit #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     is_store,
  input  logic [2:0]               funct3,
  input  logic [DATA_WIDTH-1:0]    addr,
  input  logic [DATA_WIDTH-1:0]    store_data,
  input  logic [ADDRESS_WIDTH-1:0] rd,
  output logic                     mem_req,
  output logic                     mem_we,
  output logic [DATA_WIDTH-1:0]    mem_addr,
  output logic [DATA_WIDTH-1:0]    mem_wdata,
  output logic [3:0]               mem_wstrb,
  input  logic                     mem_ready,
  input  logic [DATA_WIDTH-1:0]    mem_rdata,
  output logic                     busy,
  output logic                     done,
  output logic                     fault,
  output logic                     wb_we,
  output logic [ADDRESS_WIDTH-1:0] wb_rd,
  output logic [DATA_WIDTH-1:0]    wb_data,
  output logic [1:0]               dbg_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, DONE = 2'd2, ERR = 2'd3} state_t;

  state_t                   state, state_next;
  logic                     is_store_q;
  logic [2:0]               funct3_q;
  logic [DATA_WIDTH-1:0]    addr_q;
  logic [DATA_WIDTH-1:0]    store_data_q;
  logic [ADDRESS_WIDTH-1:0] rd_q;
  logic [ADDRESS_WIDTH-1:0] wb_rd_q;
  logic [DATA_WIDTH-1:0]    wb_data_q;
  logic                     misaligned, bad_op, illegal;
  logic [DATA_WIDTH-1:0]    lane;
  logic [DATA_WIDTH-1:0]    load_ext;

  // Handshake: mem_req is high for every REQ cycle with fixed attributes; the
  // transfer happens in the cycle mem_ready is also high (read data valid then).
  always_comb begin
    misaligned = 1'b0;
    case (funct3[1:0])
      2'b01:   misaligned = addr[0];
      2'b10:   misaligned = (addr[1:0] != 2'b00);
      default: misaligned = 1'b0;
    endcase
    if (is_store) bad_op = funct3[2] || (funct3[1:0] == 2'b11);
    else          bad_op = (funct3[1:0] == 2'b11) || (funct3 == 3'b110);
    illegal = misaligned || bad_op;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = illegal ? ERR : REQ;
      REQ:     if (mem_ready) state_next = DONE;
      DONE:    state_next = IDLE;
      ERR:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      is_store_q   <= 1'b0;
      funct3_q     <= 3'b000;
      addr_q       <= '0;
      store_data_q <= '0;
      rd_q         <= '0;
    end else if (state == IDLE && start) begin
      is_store_q   <= is_store;
      funct3_q     <= funct3;
      addr_q       <= addr;
      store_data_q <= store_data;
      rd_q         <= rd;
    end
  end

  // Select the addressed lane by shifting it down to bit 0, then extend.
  always_comb begin
    lane = mem_rdata >> {addr_q[1:0], 3'b000};
    case (funct3_q)
      3'b000:  load_ext = {{(DATA_WIDTH-8){lane[7]}}, lane[7:0]};
      3'b001:  load_ext = {{(DATA_WIDTH-16){lane[15]}}, lane[15:0]};
      3'b100:  load_ext = {{(DATA_WIDTH-8){1'b0}}, lane[7:0]};
      3'b101:  load_ext = {{(DATA_WIDTH-16){1'b0}}, lane[15:0]};
      default: load_ext = lane;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_rd_q   <= '0;
      wb_data_q <= '0;
    end else if (state == REQ && mem_ready && !is_store_q) begin
      wb_rd_q   <= rd_q;
      wb_data_q <= load_ext;
    end
  end

  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wstrb = 4'b0000;
    done      = 1'b0;
    fault     = 1'b0;
    wb_we     = 1'b0;
    busy      = (state != IDLE);
    dbg_state = state;
    case (state)
      REQ: begin
        mem_req  = 1'b1;
        mem_we   = is_store_q;
        mem_addr = {addr_q[DATA_WIDTH-1:2], 2'b00};
        if (is_store_q) begin
          case (funct3_q[1:0])
            2'b00: begin
              mem_wstrb = 4'b0001 << addr_q[1:0];
              mem_wdata = {(DATA_WIDTH/8){store_data_q[7:0]}};
            end
            2'b01: begin
              mem_wstrb = addr_q[1] ? 4'b1100 : 4'b0011;
              mem_wdata = {(DATA_WIDTH/16){store_data_q[15:0]}};
            end
            default: begin
              mem_wstrb = 4'b1111;
              mem_wdata = store_data_q;
            end
          endcase
        end
      end
      DONE: begin
        done  = 1'b1;
        wb_we = !is_store_q && (rd_q != '0);
      end
      ERR: begin
        done  = 1'b1;
        fault = 1'b1;
      end
      default: ;
    endcase
  end

  assign wb_rd   = wb_rd_q;
  assign wb_data = wb_data_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: each step drives inputs just after a
// rising edge and checks the Moore outputs of the cycle that edge started.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst, start, is_store, mem_ready;
  logic [2:0]  funct3;
  logic [31:0] addr, store_data, mem_rdata;
  logic [4:0]  rd;
  logic        mem_req, mem_we, busy, done, fault, wb_we;
  logic [31:0] mem_addr, mem_wdata, wb_data;
  logic [3:0]  mem_wstrb;
  logic [4:0]  wb_rd;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;
  int req_cycles;

  load_store_unit #(.DATA_WIDTH(32), .ADDRESS_WIDTH(5)) dut (
    .clk(clk), .rst(rst), .start(start), .is_store(is_store), .funct3(funct3),
    .addr(addr), .store_data(store_data), .rd(rd),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .busy(busy), .done(done), .fault(fault), .wb_we(wb_we), .wb_rd(wb_rd),
    .wb_data(wb_data), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse start for one cycle, then scramble the operands to prove they were captured.
  task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] sd, input logic [4:0] r);
    start = 1'b1; is_store = st; funct3 = f3; addr = a; store_data = sd; rd = r;
    tick();
    start = 1'b0; is_store = ~st; funct3 = 3'($urandom);
    addr = $urandom; store_data = $urandom; rd = 5'($urandom);
  endtask

  task automatic load_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] rdata, input logic [4:0] r,
                         input logic exp_we, input logic [31:0] exp_data);
    issue(1'b0, f3, a, 32'h0, r);
    chk({tag, "_req"}, 32'(mem_req), 32'd1);
    chk({tag, "_we"}, 32'(mem_we), 32'd0);
    chk({tag, "_addr"}, mem_addr, {a[31:2], 2'b00});
    chk({tag, "_wstrb"}, 32'(mem_wstrb), 32'd0);
    chk({tag, "_done_early"}, 32'(done), 32'd0);
    mem_ready = 1'b1; mem_rdata = rdata;
    tick();
    mem_ready = 1'b0; mem_rdata = $urandom;
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_fault"}, 32'(fault), 32'd0);
    chk({tag, "_wb_we"}, 32'(wb_we), 32'(exp_we));
    chk({tag, "_req_drop"}, 32'(mem_req), 32'd0);
    if (exp_we) begin
      chk({tag, "_wb_data"}, wb_data, exp_data);
      chk({tag, "_wb_rd"}, 32'(wb_rd), 32'(r));
    end
    tick();
    chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
    chk({tag, "_idle_done"}, 32'(done), 32'd0);
  endtask

  task automatic store_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] sd, input logic [31:0] exp_addr,
                          input logic [3:0] exp_strb, input logic [31:0] exp_wdata);
    issue(1'b1, f3, a, sd, 5'd1);
    chk({tag, "_req"}, 32'(mem_req), 32'd1);
    chk({tag, "_we"}, 32'(mem_we), 32'd1);
    chk({tag, "_addr"}, mem_addr, exp_addr);
    chk({tag, "_wstrb"}, 32'(mem_wstrb), 32'(exp_strb));
    chk({tag, "_wdata"}, mem_wdata, exp_wdata);
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_wb_we"}, 32'(wb_we), 32'd0);
    tick();
    chk({tag, "_idle_done"}, 32'(done), 32'd0);
  endtask

  task automatic fault_op(input string tag, input logic st, input logic [2:0] f3,
                          input logic [31:0] a);
    issue(st, f3, a, 32'h5555_AAAA, 5'd7);
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_fault"}, 32'(fault), 32'd1);
    chk({tag, "_req"}, 32'(mem_req), 32'd0);
    chk({tag, "_wb_we"}, 32'(wb_we), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    tick();
    chk({tag, "_after_done"}, 32'(done), 32'd0);
    chk({tag, "_after_fault"}, 32'(fault), 32'd0);
    chk({tag, "_after_req"}, 32'(mem_req), 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; is_store = 1'b0; funct3 = 3'b000; addr = '0;
    store_data = '0; rd = '0; mem_ready = 1'b0; mem_rdata = '0;
    tick();
    tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    chk("rst_wstrb", 32'(mem_wstrb), 32'd0);
    chk("rst_wb_we", 32'(wb_we), 32'd0);
    chk("rst_wb_rd", 32'(wb_rd), 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_state", 32'(dbg_state), 32'd0);
    rst = 1'b0;
    tick();

    load_op("lw",  3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 5'd5, 1'b1, 32'hDEAD_BEEF);
    load_op("lb",  3'b000, 32'h0000_0103, 32'h80FF_0011, 5'd6, 1'b1, 32'hFFFF_FF80);
    load_op("lbu", 3'b100, 32'h0000_0103, 32'h80FF_0011, 5'd6, 1'b1, 32'h0000_0080);
    store_op("sh", 3'b001, 32'h0000_0206, 32'h1234_ABCD, 32'h0000_0204, 4'b1100, 32'hABCD_ABCD);
    chk("sh_wb_hold", wb_data, 32'h0000_0080);
    store_op("sb", 3'b000, 32'h0000_0301, 32'h0000_00A5, 32'h0000_0300, 4'b0010, 32'hA5A5_A5A5);
    store_op("sh_lo", 3'b001, 32'h0000_0010, 32'hFFFF_5A5A, 32'h0000_0010, 4'b0011, 32'h5A5A_5A5A);
    store_op("sw", 3'b010, 32'h0000_0040, 32'hCAFE_F00D, 32'h0000_0040, 4'b1111, 32'hCAFE_F00D);
    load_op("lh",  3'b001, 32'h0000_0102, 32'h8001_7F00, 5'd9, 1'b1, 32'hFFFF_8001);
    load_op("lhu", 3'b101, 32'h0000_0102, 32'h8001_7F00, 5'd9, 1'b1, 32'h0000_8001);
    load_op("lb_pos", 3'b000, 32'h0000_0001, 32'h8001_7F00, 5'd2, 1'b1, 32'h0000_007F);

    fault_op("lw_mis", 1'b0, 3'b010, 32'h0000_0102);
    fault_op("lh_mis", 1'b0, 3'b001, 32'h0000_0011);
    fault_op("ld_f3", 1'b0, 3'b011, 32'h0000_0000);
    fault_op("st_f3", 1'b1, 3'b100, 32'h0000_0300);

    // mem_ready while idle must not start anything.
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    chk("idle_ready_busy", 32'(busy), 32'd0);
    chk("idle_ready_req", 32'(mem_req), 32'd0);

    // Slow memory: ready first seen in cycle 5, with a stray start in cycle 3.
    req_cycles = 0;
    issue(1'b0, 3'b010, 32'h0000_0040, 32'h0, 5'd3);
    for (int c = 1; c <= 5; c++) begin
      chk("wait_done_low", 32'(done), 32'd0);
      chk("wait_addr", mem_addr, 32'h0000_0040);
      if (mem_req) req_cycles++;
      if (c == 3) begin
        start = 1'b1; is_store = 1'b1; funct3 = 3'b000; addr = 32'h0000_0081; rd = 5'd4;
      end else begin
        start = 1'b0;
      end
      if (c == 5) begin
        mem_ready = 1'b1; mem_rdata = 32'h1122_3344;
      end
      tick();
    end
    start = 1'b0; mem_ready = 1'b0;
    chk("wait_req_cycles", 32'(req_cycles), 32'd5);
    chk("wait_done_c6", 32'(done), 32'd1);
    chk("wait_wb_data", wb_data, 32'h1122_3344);
    chk("wait_wb_rd", 32'(wb_rd), 32'd3);
    tick();
    chk("wait_c7_done", 32'(done), 32'd0);
    chk("wait_c7_req", 32'(mem_req), 32'd0);
    chk("wait_c7_busy", 32'(busy), 32'd0);

    load_op("lw_r0", 3'b010, 32'h0000_0080, 32'h0BAD_F00D, 5'd0, 1'b0, 32'h0);

    // Reset while a request is outstanding, racing a mem_ready.
    issue(1'b0, 3'b010, 32'h0000_0010, 32'h0, 5'd9);
    chk("rreq_req", 32'(mem_req), 32'd1);
    rst = 1'b1; mem_ready = 1'b1; mem_rdata = 32'h7777_7777;
    tick();
    rst = 1'b0; mem_ready = 1'b0;
    chk("rreq_req_drop", 32'(mem_req), 32'd0);
    chk("rreq_done", 32'(done), 32'd0);
    chk("rreq_wb_we", 32'(wb_we), 32'd0);
    chk("rreq_busy", 32'(busy), 32'd0);
    chk("rreq_wb_data", wb_data, 32'd0);
    tick();
    chk("rreq_done_later", 32'(done), 32'd0);
    chk("rreq_req_later", 32'(mem_req), 32'd0);

    load_op("post_rst_lw", 3'b010, 32'h0000_0020, 32'h0102_0304, 5'd31, 1'b1, 32'h0102_0304);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
